// File: rtl/btn_debouncer.sv
// ---------------------------------------------------------------------------
// btn_debouncer
//
// Conditions an asynchronous, bouncing pushbutton or switch level so it can
// feed the signal input of the 3-bit sequence-detector FSM. The raw level is
// first brought into the clk domain through a two-flop synchroniser. A new
// synchronised level is accepted only after it has held for STABLE_CYCLES
// consecutive cycles. Any return to the current level restarts the
// qualification from zero.
//
// When a new level is accepted, a one-cycle rise or fall strobe is also
// produced for logic downstream that wants edges rather than levels.
//
// Parameters:
//   STABLE_CYCLES  consecutive synchronised cycles a new level must hold
//                  before it is accepted (legal range 2..65535)
//
// Ports:
//   clk     in   single clock for all state
//   rst     in   synchronous active-high reset, sampled on rising clk
//   raw_in  in   asynchronous, possibly bouncing input level
//   signal  out  debounced level
//   rise    out  one-cycle strobe when signal goes 0->1
//   fall    out  one-cycle strobe when signal goes 1->0
// ---------------------------------------------------------------------------
module btn_debouncer #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic signal,
   output logic rise,
   output logic fall
);

   // The counter only has to reach STABLE_CYCLES-1. For any legal value
   // (2 or more), $clog2(STABLE_CYCLES) is the smallest width that holds it.
   localparam int unsigned     CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      IDLE,
      CHECK
   } state_t;

   logic             s1;
   logic             s2;
   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             signal_d;
   logic             rise_d;
   logic             fall_d;
   logic             differs;

   // Two-flop synchroniser. raw_in is asynchronous, so only s2 is trusted by
   // the qualification logic. s1 may be metastable and is never looked at
   // anywhere else. Both flops are cleared by reset. As a result, a level
   // that is already high when reset releases is seen as a fresh 0->1
   // transition and is qualified normally.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw_in;
         s2 <= s1;
      end
   end

   // State register for the qualifier, together with the registered outputs.
   // Reset takes priority over everything else. A count in progress is
   // thrown away, and no strobe can escape on the reset edge, because the
   // strobes are cleared here rather than taken from the next-state logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         signal  <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         signal  <= signal_d;
         rise    <= rise_d;
         fall    <= fall_d;
      end
   end

   // Next-state logic.
   //
   // IDLE means the synchronised input agrees with the accepted level. The
   // first disagreeing cycle moves to CHECK with the count already at one,
   // because that cycle is the first of the run being qualified. In CHECK,
   // each further disagreeing cycle advances the count. On the cycle the
   // count is already at STABLE_CYCLES-1, the run is long enough: the new
   // level is committed and the matching strobe is raised for that one
   // cycle. Any agreeing cycle while in CHECK drops back to IDLE with the
   // count cleared, so a glitch can never accumulate credit across gaps.
   //
   // A commit always returns to IDLE with a zero count. The opposite level
   // can therefore start qualifying on the very next edge, and the counter
   // has no path past CNT_MAX.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      signal_d = signal;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      differs  = (s2 != signal);

      case (state_q)
         IDLE: begin
            if (differs) begin
               state_d = CHECK;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end

         CHECK: begin
            if (!differs) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d  = IDLE;
               cnt_d    = '0;
               signal_d = s2;
               rise_d   = s2;
               fall_d   = ~s2;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule
